// File: rtl/magia_l2_pkg.sv
// magia_l2_pkg: shared constants, width helpers and response type for the banked L2 scratchpad
package magia_l2_pkg;
  localparam logic [31:0] L2_BASE_ADDR = 32'h1C00_0000;
  localparam int unsigned L2_DATA_W = 32;
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int unsigned BankSelW = idx_w(4);
  localparam int unsigned RowW = idx_w(1024);
  typedef struct packed {
    logic valid;
    logic err;
    logic [L2_DATA_W-1:0] data;
  } l2_resp_t;
endpackage

// File: rtl/magia_l2_rr_arb.sv
// magia_l2_rr_arb: round-robin arbiter, lowest requester at or after the pointer wins
module magia_l2_rr_arb
  import magia_l2_pkg::*;
#(
  parameter int unsigned NumReq = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] gnt
);
  localparam int unsigned IdxW = idx_w(NumReq);
  logic [IdxW-1:0] ptr, ptr_nxt, idx;
  logic found;
  always_comb begin
    gnt = '0;
    ptr_nxt = ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = IdxW'((int'(ptr) + i) % NumReq);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt = IdxW'((int'(idx) + 1) % NumReq);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (found) ptr <= ptr_nxt;
  end
endmodule

// File: rtl/magia_l2_banked_mem.sv
// magia_l2_banked_mem: multi-port word-interleaved L2 scratchpad with per-bank round-robin arbitration
module magia_l2_banked_mem
  import magia_l2_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned NumBanks = 4,
  parameter int unsigned BankWords = 1024,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency = 1,
  parameter logic [AddrWidth-1:0] BaseAddr = AddrWidth'(L2_BASE_ADDR)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumPorts-1:0]                   req_i,
  input  logic [NumPorts-1:0]                   we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0]  be_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]    wdata_i,
  output logic [NumPorts-1:0]                   gnt_o,
  output logic [NumPorts-1:0]                   rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]    rdata_o,
  output logic [NumPorts-1:0]                   rerr_o,
  output logic [31:0]                           conflict_cnt_o
);
  localparam int unsigned SelW = idx_w(NumBanks);
  localparam int unsigned BankShift = $clog2(NumBanks);
  localparam int unsigned RowAw = idx_w(BankWords);
  localparam int unsigned BeW = DataWidth / 8;
  localparam longint unsigned Cap = longint'(NumBanks) * longint'(BankWords) * 4;

  if (NumPorts < 1 || NumPorts > 32 || NumBanks < 1 || NumBanks > 16 ||
      (NumBanks & (NumBanks - 1)) != 0 || BankWords < 2 || (BankWords & (BankWords - 1)) != 0 ||
      DataWidth == 0 || DataWidth % 8 != 0 || Latency < 1 || Latency > 4) begin : g_bad_param
    $error("magia_l2_banked_mem: illegal parameter set");
  end

  typedef struct packed {
    logic valid;
    logic err;
    logic [DataWidth-1:0] data;
  } resp_t;

  logic [NumPorts-1:0][AddrWidth-1:0] off;
  logic [NumPorts-1:0][SelW-1:0] bank;
  logic [NumPorts-1:0][RowAw-1:0] row;
  logic [NumPorts-1:0] oor;
  logic [NumPorts-1:0] bank_req [NumBanks];
  logic [NumPorts-1:0] bank_gnt [NumBanks];
  logic [NumBanks-1:0] wen;
  logic [RowAw-1:0] wrow [NumBanks];
  logic [BeW-1:0] wbe [NumBanks];
  logic [DataWidth-1:0] wdat [NumBanks];
  logic [DataWidth-1:0] mem [NumBanks][BankWords];
  resp_t pipe [NumPorts][Latency];
  logic [32:0] cnt_sum;
  logic [31:0] cnt;

  // Out-of-range ports bypass the banks and never compete for a grant
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      off[p] = addr_i[p] - BaseAddr;
      oor[p] = (addr_i[p] < BaseAddr) || (64'(off[p]) >= Cap);
      bank[p] = (NumBanks > 1) ? off[p][2 +: SelW] : '0;
      row[p] = off[p][2 + BankShift +: RowAw];
    end
    for (int b = 0; b < NumBanks; b++)
      for (int p = 0; p < NumPorts; p++)
        bank_req[b][p] = req_i[p] & ~rst_i & ~oor[p] & (bank[p] == SelW'(b));
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    magia_l2_rr_arb #(.NumReq(NumPorts)) u_arb (
      .clk(clk_i),
      .rst(rst_i),
      .req(bank_req[b]),
      .gnt(bank_gnt[b])
    );
  end

  always_comb begin
    gnt_o = req_i & oor & {NumPorts{~rst_i}};
    for (int b = 0; b < NumBanks; b++) begin
      wen[b] = 1'b0;
      wrow[b] = '0;
      wbe[b] = '0;
      wdat[b] = '0;
      for (int p = 0; p < NumPorts; p++) begin
        if (bank_gnt[b][p]) begin
          gnt_o[p] = 1'b1;
          wen[b] = we_i[p];
          wrow[b] = row[p];
          wbe[b] = be_i[p];
          wdat[b] = wdata_i[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++)
      if (wen[b])
        for (int k = 0; k < BeW; k++)
          if (wbe[b][k]) mem[b][wrow[b]][8*k +: 8] <= wdat[b][8*k +: 8];
  end

  // Read data is captured at the grant edge, before that edge's write lands
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (rst_i) begin
        for (int s = 0; s < Latency; s++) pipe[p][s] <= '0;
      end else begin
        pipe[p][0] <= '{valid: gnt_o[p], err: gnt_o[p] & oor[p],
                        data: (gnt_o[p] & ~oor[p] & ~we_i[p]) ? mem[bank[p]][row[p]] : '0};
        for (int s = 1; s < Latency; s++) pipe[p][s] <= pipe[p][s-1];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rvalid_o[p] = pipe[p][Latency-1].valid;
      rerr_o[p] = pipe[p][Latency-1].err;
      rdata_o[p] = pipe[p][Latency-1].data;
    end
  end

  always_comb cnt_sum = {1'b0, cnt} + 33'($countones(req_i & ~gnt_o));

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end

  assign conflict_cnt_o = cnt;
endmodule

// File: tb/tb_magia_l2_banked_mem.sv
// tb_magia_l2_banked_mem: scoreboard bench driving Latency=1 and Latency=3 instances with shared stimulus
module tb_magia_l2_banked_mem;
  localparam logic [31:0] B = 32'h1C00_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] we = '0;
  logic [3:0][31:0] addr = '0;
  logic [3:0][31:0] wd = '0;
  logic [3:0][3:0] be = '0;
  logic [3:0] gnt [2];
  logic [3:0] rv [2];
  logic [3:0] rerr [2];
  logic [3:0][31:0] rd [2];
  logic [31:0] cnt [2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  typedef struct {
    int due;
    logic err;
    logic [31:0] data;
  } exp_t;
  exp_t q [8][$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  magia_l2_banked_mem #(.Latency(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wd),
    .gnt_o(gnt[0]), .rvalid_o(rv[0]), .rdata_o(rd[0]), .rerr_o(rerr[0]), .conflict_cnt_o(cnt[0])
  );

  magia_l2_banked_mem #(.Latency(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wd),
    .gnt_o(gnt[1]), .rvalid_o(rv[1]), .rdata_o(rd[1]), .rerr_o(rerr[1]), .conflict_cnt_o(cnt[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic setp(input int p, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d);
    req[p] = 1'b1;
    we[p] = w;
    addr[p] = a;
    be[p] = b;
    wd[p] = d;
  endtask

  task automatic nxt();
    @(negedge clk);
    req = '0;
    we = '0;
  endtask

  // Check grants and counter, then queue one expected response per expected grant
  task automatic issue(input logic [3:0] eg, input logic [3:0] ee, input logic [31:0] e0,
                       input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ed [4];
    ed[0] = e0; ed[1] = e1; ed[2] = e2; ed[3] = e3;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("gnt dut%0d", d), 32'(gnt[d]), 32'(eg));
      chk($sformatf("conflict_cnt dut%0d", d), cnt[d], 32'(exp_cnt));
    end
    for (int p = 0; p < 4; p++)
      if (eg[p])
        for (int d = 0; d < 2; d++)
          q[d*4+p].push_back(exp_t'{due: cyc + (d == 0 ? 1 : 3), err: ee[p], data: ed[p]});
    exp_cnt += $countones(req & ~eg);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 4; p++) begin
        while (q[d*4+p].size() > 0 && q[d*4+p][0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL rvalid dut%0d port%0d: got none, expected at cycle %0d", d, p, q[d*4+p][0].due);
          void'(q[d*4+p].pop_front());
        end
        if (rv[d][p]) begin
          if (q[d*4+p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid dut%0d port%0d: got 1 at cycle %0d, expected 0", d, p, cyc);
          end else begin
            e = q[d*4+p].pop_front();
            chk($sformatf("rsp_cycle dut%0d port%0d", d, p), 32'(cyc), 32'(e.due));
            chk($sformatf("rerr dut%0d port%0d", d, p), 32'(rerr[d][p]), 32'(e.err));
            chk($sformatf("rdata dut%0d port%0d", d, p), rd[d][p], e.data);
          end
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 4; p++) setp(p, 1'b0, B + 32'(4*p), 4'hF, 0);
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset gnt", 32'(gnt[d]), 0);
      chk("reset rvalid", 32'(rv[d]), 0);
      chk("reset rerr", 32'(rerr[d]), 0);
      chk("reset cnt", cnt[d], 0);
      for (int p = 0; p < 4; p++) chk("reset rdata", rd[d][p], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    // four writers on one bank: rotate 0,1,2,3 with 3+2+1+0 denials
    for (int c = 0; c < 4; c++) begin
      nxt();
      for (int p = c; p < 4; p++) setp(p, 1'b1, B + 32'h10, 4'hF, 32'h1111_0000 + 32'(p));
      issue(4'(1 << c), 4'b0000, 0, 0, 0, 0);
    end
    nxt(); setp(0, 1'b1, B, 4'hF, 32'hDEAD_BEEF);
    issue(4'b0001, 4'b0000, 0, 0, 0, 0);
    nxt(); setp(0, 1'b0, B, 4'hF, 0);
    issue(4'b0001, 4'b0000, 32'hDEAD_BEEF, 0, 0, 0);
    nxt(); for (int p = 0; p < 4; p++) setp(p, 1'b1, B + 32'(4*p), 4'hF, 32'hC0DE_0000 + 32'(p));
    issue(4'b1111, 4'b0000, 0, 0, 0, 0);
    nxt(); for (int p = 0; p < 4; p++) setp(p, 1'b0, B + 32'(4*p), 4'hF, 0);
    issue(4'b1111, 4'b0000, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
    nxt(); setp(1, 1'b1, B + 32'h24, 4'hF, 32'hFFFF_FFFF);
    issue(4'b0010, 4'b0000, 0, 0, 0, 0);
    nxt(); setp(1, 1'b1, B + 32'h24, 4'b0101, 32'h1234_5678);
    issue(4'b0010, 4'b0000, 0, 0, 0, 0);
    nxt(); setp(1, 1'b0, B + 32'h24, 4'hF, 0); setp(2, 1'b0, B + 32'h10, 4'hF, 0);
    issue(4'b0110, 4'b0000, 0, 32'hFF34_FF78, 32'h1111_0003, 0);
    nxt();
    setp(0, 1'b1, 32'h1C00_4000, 4'hF, 32'hAAAA_AAAA);
    setp(1, 1'b1, 32'h1C00_3FFC, 4'hF, 32'h5555_AAAA);
    setp(2, 1'b0, 32'h1C00_4000, 4'hF, 0);
    setp(3, 1'b0, 32'h1BFF_FFFC, 4'hF, 0);
    issue(4'b1111, 4'b1101, 0, 0, 0, 0);
    nxt(); setp(0, 1'b0, B, 4'hF, 0); setp(1, 1'b0, 32'h1C00_3FFC, 4'hF, 0);
    issue(4'b0011, 4'b0000, 32'hC0DE_0000, 32'h5555_AAAA, 0, 0);
    // bank 0 pointer sits at 1 here, so port 2 beats port 0, then port 0 wins after wrap
    nxt(); setp(0, 1'b0, B, 4'hF, 0); setp(2, 1'b0, B + 32'h10, 4'hF, 0);
    issue(4'b0100, 4'b0000, 0, 0, 32'h1111_0003, 0);
    nxt(); setp(0, 1'b0, B, 4'hF, 0);
    issue(4'b0001, 4'b0000, 32'hC0DE_0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); setp(0, 1'b0, B + 32'(4*i), 4'hF, 0);
      issue(4'b0001, 4'b0000, 32'hC0DE_0000 + 32'(i), 0, 0, 0);
    end
    @(posedge clk);
    #1;
    req = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) q[k].delete();
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rvalid after reset dut0", 32'(rv[0]), 0);
      chk("rvalid after reset dut1", 32'(rv[1]), 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    nxt(); setp(1, 1'b0, B + 32'h24, 4'hF, 0);
    issue(4'b0010, 4'b0000, 0, 32'hFF34_FF78, 0, 0);
    nxt();
    repeat (5) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("final conflict_cnt", cnt[d], 32'(exp_cnt));
    for (int k = 0; k < 8; k++) chk($sformatf("pending rsp q%0d", k), 32'(q[k].size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
